// File: rtl/mem_packer_pkg.sv
// Shared types and constants for the memory word packer.
package mem_packer_pkg;
  localparam int K_LANES = 4;
  localparam int K_IDX_W = $clog2(K_LANES);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} pk_state_t;
  typedef logic [K_LANES-1:0] lane_mask_t;
endpackage

// File: rtl/mem_packer_bank.sv
// One packing bank: lane storage, lane-valid mask, write index, FILL/HOLD state.
// A bank fills lanes in order, parks in HOLD once complete, and is wiped on release.
module mem_packer_bank
  import mem_packer_pkg::*;
#(
  parameter int K_DWIDTH = 8
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              wr_en,
  input  logic [K_DWIDTH-1:0]               wr_word,
  input  logic                              wr_last,
  input  logic                              rd_en,
  output pk_state_t                         state,
  output logic [K_LANES-1:0][K_DWIDTH-1:0]  mem,
  output lane_mask_t                        mask
);

  logic [K_IDX_W-1:0] idx;

  // Fill lanes in order; close on the last lane or an early i_last; clear on release.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= FILL;
      idx   <= '0;
      mask  <= '0;
      mem   <= '0;
    end else if (state == HOLD) begin
      if (rd_en) begin
        state <= FILL;
        idx   <= '0;
        mask  <= '0;
        mem   <= '0;
      end
    end else if (wr_en) begin
      mem[idx]  <= wr_word;
      mask[idx] <= 1'b1;
      idx       <= idx + 1'b1;
      if (wr_last || (idx == K_IDX_W'(K_LANES - 1)))
        state <= HOLD;
    end
  end

endmodule

// File: rtl/mem_packer.sv
// Packs upstream memory words into K_LANES-wide frames with a lane-valid mask.
// Optional feature: define MEM_PACKER_PINGPONG_EN for two alternating banks,
// which lets input fill one bank while the other waits for the consumer.
module mem_packer
  import mem_packer_pkg::*;
#(
  parameter int K_DWIDTH = 8,
  parameter int K_LANES  = mem_packer_pkg::K_LANES
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic [K_DWIDTH-1:0]               i_word,
  input  logic                              i_last,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [K_LANES-1:0][K_DWIDTH-1:0]  o_mem,
  output logic [K_LANES-1:0]                o_data,
  output logic [15:0]                       o_frames
);

`ifdef MEM_PACKER_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  pk_state_t                                bank_state [NB];
  logic [NB-1:0][K_LANES-1:0][K_DWIDTH-1:0] bank_mem;
  lane_mask_t                               bank_mask  [NB];

  logic        wr_sel;
  logic        rd_sel;
  logic        accept;
  logic        hs;
  logic [15:0] frames_q;

  for (genvar b = 0; b < NB; b++) begin : g_bank
    mem_packer_bank #(.K_DWIDTH(K_DWIDTH)) u_bank (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .wr_en   (accept && (wr_sel == 1'(b))),
      .wr_word (i_word),
      .wr_last (i_last),
      .rd_en   (hs && (rd_sel == 1'(b))),
      .state   (bank_state[b]),
      .mem     (bank_mem[b]),
      .mask    (bank_mask[b])
    );
  end

  // Input side is ready whenever the bank being written still has room.
  assign o_ready  = !i_rst && (bank_state[wr_sel] == FILL);
  assign accept   = i_valid && o_ready;
  assign o_valid  = (bank_state[rd_sel] == HOLD);
  assign hs       = o_valid && i_ready;
  assign o_mem    = bank_mem[rd_sel];
  assign o_data   = bank_mask[rd_sel];
  assign o_frames = frames_q;

`ifdef MEM_PACKER_PINGPONG_EN
  // Write pointer moves on the completing accept (lanes fill in order, so mask
  // bit K_LANES-2 set means this accept lands in the last lane); read pointer
  // moves on each delivered frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
    end else begin
      if (accept && (i_last || bank_mask[wr_sel][K_LANES-2]))
        wr_sel <= ~wr_sel;
      if (hs)
        rd_sel <= ~rd_sel;
    end
  end
`else
  assign wr_sel = 1'b0;
  assign rd_sel = 1'b0;
`endif

  // Delivered-frame counter, wraps naturally at 16 bits.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)   frames_q <= '0;
    else if (hs) frames_q <= frames_q + 16'd1;
  end

endmodule

// File: tb/tb_mem_packer.sv
// Scoreboard bench for mem_packer: the driver models each accepted word and
// queues the expected frame; a negedge monitor compares every delivered frame.
module tb_mem_packer;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_valid = 1'b0;
  logic            o_ready;
  logic [7:0]      i_word = '0;
  logic            i_last = 1'b0;
  logic            o_valid;
  logic            i_ready = 1'b1;
  logic [3:0][7:0] o_mem;
  logic [3:0]      o_data;
  logic [15:0]     o_frames;

  mem_packer #(.K_DWIDTH(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_word(i_word), .i_last(i_last), .o_valid(o_valid), .i_ready(i_ready),
    .o_mem(o_mem), .o_data(o_data), .o_frames(o_frames)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0][7:0] mem;
    logic [3:0]      mask;
  } frame_t;

  frame_t          sb[$];
  logic [3:0][7:0] m_mem  = '0;
  logic [3:0]      m_mask = '0;
  int              m_idx  = 0;
  logic [15:0]     exp_frames = '0;
  int              n_chk  = 0;
  int              n_fail = 0;
  int              stalls = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_mem = '0; m_mask = '0; m_idx = 0;
  endtask

  task automatic model_accept(input logic [7:0] w, input logic last);
    frame_t f;
    m_mem[m_idx]  = w;
    m_mask[m_idx] = 1'b1;
    m_idx++;
    if (m_idx == 4 || last) begin
      f.mem = m_mem; f.mask = m_mask;
      sb.push_back(f);
      model_clear();
    end
  endtask

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  // Present one word until accepted; idle inputs get junk to show they are ignored.
  task automatic send(input logic [7:0] w, input logic last);
    logic rdy;
    bit   done;
    done = 0;
    i_valid = 1'b1; i_word = w; i_last = last;
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge i_clk); rdy = o_ready;
      if (!rdy) stalls++;
      tick();
      if (rdy) begin done = 1; model_accept(w, last); end
    end
    i_valid = 1'b0; i_word = 8'($urandom); i_last = 1'($urandom);
    if (!done) chk("send_timeout", 0, 1);
  endtask

  // Monitor: pop and compare on every output handshake.
  initial begin
    frame_t f;
    forever begin
      @(negedge i_clk);
      if (i_rst) exp_frames = '0;
      else if (o_valid && i_ready) begin
        if (sb.size() == 0) chk("unexpected_frame", {60'd0, o_data}, 64'hdead);
        else begin
          f = sb.pop_front();
          chk("frame_mem",  o_mem,    f.mem);
          chk("frame_mask", o_data,   f.mask);
          chk("frame_cnt",  o_frames, exp_frames);
        end
        exp_frames = exp_frames + 16'd1;
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(negedge i_clk);
    chk("rst_ready",  o_ready,  0);
    chk("rst_valid",  o_valid,  0);
    chk("rst_mem",    o_mem,    0);
    chk("rst_data",   o_data,   0);
    chk("rst_frames", o_frames, 0);
    i_rst = 1'b0;
    tick();
    chk("post_rst_ready", o_ready, 1);

    // Full frame, valid one cycle after the 4th accept
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    chk("full_valid_lat", o_valid, 1);
    repeat (2) @(negedge i_clk);
    chk("full_frames", o_frames, 1);

    // Early close with i_last: lanes 2-3 zero
    tick();
    send(8'hA0, 0); send(8'hA1, 1);
    chk("last_valid", o_valid, 1);
    chk("last_mask",  o_data,  4'b0011);
    chk("last_mem",   o_mem,   32'h0000_A1A0);
    repeat (3) tick();

    // Back-pressure: frame held stable while i_ready=0
    i_ready = 1'b0;
    send(8'hB0, 0); send(8'hB1, 0); send(8'hB2, 0); send(8'hB3, 0);
`ifndef MEM_PACKER_PINGPONG_EN
    i_valid = 1'b1; i_word = 8'hEE; i_last = 1'b0;
`endif
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      chk("hold_valid",  o_valid,  1);
      chk("hold_mem",    o_mem,    32'hB3B2_B1B0);
      chk("hold_mask",   o_data,   4'b1111);
      chk("hold_frames", o_frames, 2);
`ifndef MEM_PACKER_PINGPONG_EN
      chk("hold_ready",  o_ready,  0);
`endif
    end
    tick();
    i_valid = 1'b0; i_ready = 1'b1;
    tick();
    send(8'hC0, 1);
    repeat (3) @(negedge i_clk);
    chk("after_hold_frames", o_frames, 4);

    // Reset mid-frame discards the partial frame
    tick();
    send(8'h55, 0); send(8'h66, 0);
    i_rst = 1'b1;
    model_clear();
    @(negedge i_clk);
    chk("midrst_ready", o_ready, 0);
    i_rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      chk("midrst_valid", o_valid, 0);
    end
    chk("midrst_frames", o_frames, 0);
    tick();
    send(8'h71, 0); send(8'h72, 0); send(8'h73, 0); send(8'h74, 0);
    repeat (3) @(negedge i_clk);
    chk("midrst_next_frames", o_frames, 1);

    // Streaming 16 words with i_ready=1
    tick();
    stalls = 0;
    for (int i = 0; i < 16; i++) send(8'(8'h80 + i), 0);
    repeat (4) @(negedge i_clk);
`ifdef MEM_PACKER_PINGPONG_EN
    chk("pp_no_stall", stalls, 0);
`endif
    chk("stream_frames", o_frames, 5);

    // Counter wrap: preload near the top, then deliver two frames
    tick();
    force dut.frames_q = 16'hFFFE;
    exp_frames = 16'hFFFE;
    @(negedge i_clk);
    release dut.frames_q;
    tick();
    send(8'hD0, 1);
    send(8'hD1, 1);
    repeat (4) @(negedge i_clk);
    chk("wrap_frames", o_frames, 0);

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
